// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the CHARIS datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic        Instr_LdEn,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        MEM_WrEn,
    output logic        ByteOp,
    output logic        Illegal,
    output logic [31:0] Instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_BRANCH,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  opcode_q;
    logic [5:0]  opcode_d;
    logic [5:0]  func_q;
    logic [5:0]  func_d;
    logic [31:0] instr_count_q;
    logic [31:0] instr_count_d;

    logic op_r;
    logic op_imm;
    logic op_br;
    logic op_ld;
    logic op_st;
    logic op_byte;
    logic op_legal;
    logic retire;

    logic       instr_ld;
    logic       pc_ld;
    logic       pc_sel;
    logic       rf_wr;
    logic       rf_wd_sel;
    logic       rf_b_sel;
    logic       alu_bin_sel;
    logic [3:0] alu_func;
    logic       mem_wr;
    logic       byte_op;
    logic       illegal;

    // Opcode classes come only from the latched opcode, never from Instr.
    assign op_r    = (opcode_q == OP_RTYPE);
    assign op_imm  = (opcode_q == OP_LI)   ||
                     (opcode_q == OP_LUI)  ||
                     (opcode_q == OP_ADDI) ||
                     (opcode_q == OP_ANDI) ||
                     (opcode_q == OP_ORI);
    assign op_br   = (opcode_q == OP_B)    ||
                     (opcode_q == OP_BEQ)  ||
                     (opcode_q == OP_BNE);
    assign op_ld   = (opcode_q == OP_LB)   ||
                     (opcode_q == OP_LW);
    assign op_st   = (opcode_q == OP_SB)   ||
                     (opcode_q == OP_SW);
    assign op_byte = (opcode_q == OP_LB)   ||
                     (opcode_q == OP_SB);
    assign op_legal = op_r | op_imm | op_br | op_ld | op_st;

    // Terminal states are where an instruction retires.
    assign retire = (state_q == S_WB_ALU) ||
                    (state_q == S_WB_MEM) ||
                    (state_q == S_BRANCH) ||
                    (state_q == S_MEM_WR);

    // State, latched opcode/func and retire counter, synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q       <= S_FETCH;
            opcode_q      <= 6'd0;
            func_q        <= 6'd0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            func_q        <= func_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Opcode/func capture in FETCH and retirement counting (wraps).
    always_comb begin
        opcode_d      = opcode_q;
        func_d        = func_q;
        instr_count_d = instr_count_q + {31'd0, retire};
        if (state_q == S_FETCH) begin
            opcode_d = Instr[31:26];
            func_d   = Instr[5:0];
        end
    end

    // Next-state sequencing per instruction class.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    op_r:         state_d = S_EXEC_R;
                    op_imm:       state_d = S_EXEC_I;
                    op_br:        state_d = S_BRANCH;
                    op_ld, op_st: state_d = S_MEM_ADDR;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = op_ld ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_WB_MEM;
            S_WB_ALU:   state_d = S_FETCH;
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_MEM_WR:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from state and latched opcode/func.
    always_comb begin
        instr_ld    = 1'b0;
        pc_ld       = retire;
        pc_sel      = 1'b0;
        rf_wr       = 1'b0;
        rf_wd_sel   = 1'b0;
        rf_b_sel    = 1'b0;
        alu_bin_sel = 1'b0;
        alu_func    = ALU_ADD;
        mem_wr      = 1'b0;
        byte_op     = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                instr_ld = 1'b1;
            end
            S_DECODE: begin
                rf_b_sel = ~op_r;
                if (!op_legal) begin
                    illegal = 1'b1;
                    pc_ld   = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
                rf_wr     = (state_q == S_WB_ALU);
                rf_wd_sel = 1'b0;
                if (op_r) begin
                    alu_func    = func_q[3:0];
                    alu_bin_sel = 1'b0;
                    rf_b_sel    = 1'b0;
                end else begin
                    alu_bin_sel = 1'b1;
                    if (opcode_q == OP_ANDI) begin
                        alu_func = ALU_AND;
                    end else if (opcode_q == OP_ORI) begin
                        alu_func = ALU_OR;
                    end
                end
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM: begin
                alu_bin_sel = 1'b1;
                rf_b_sel    = 1'b1;
                byte_op     = op_byte;
                mem_wr      = (state_q == S_MEM_WR);
                rf_wr       = (state_q == S_WB_MEM);
                rf_wd_sel   = (state_q == S_WB_MEM);
            end
            S_BRANCH: begin
                rf_b_sel = 1'b1;
                alu_func = ALU_SUB;
                if (opcode_q == OP_B) begin
                    pc_sel = 1'b1;
                end else if (opcode_q == OP_BEQ) begin
                    pc_sel = Zero;
                end else if (opcode_q == OP_BNE) begin
                    pc_sel = ~Zero;
                end
            end
            default: begin
                pc_ld = 1'b0;
            end
        endcase
    end

    // Reset low squashes every write/enable so an aborted op has no effect.
    assign Instr_LdEn    = Rst_n & instr_ld;
    assign PC_LdEn       = Rst_n & pc_ld;
    assign PC_sel        = Rst_n & pc_sel;
    assign RF_WrEn       = Rst_n & rf_wr;
    assign MEM_WrEn      = Rst_n & mem_wr;
    assign Illegal       = Rst_n & illegal;
    assign ALU_func      = Rst_n ? alu_func : 4'b0000;
    assign RF_WrData_sel = rf_wd_sel;
    assign RF_B_sel      = rf_b_sel;
    assign ALU_Bin_sel   = alu_bin_sel;
    assign ByteOp        = byte_op;
    assign Instr_count   = instr_count_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the CHARIS datapath. It latches the fetched instruction and sequences IFSTAGE, DECSTAGE, EXSTAGE and MEMSTAGE across FETCH/DECODE/EXEC/MEM/WB states. It drives every datapath select and enable, including DECSTAGE's RF_WrEn, RF_WrData_sel and RF_B_sel. It also counts retired instructions and flags illegal opcodes.

## Interface
- No parameters; widths fixed by the CHARIS ISA.
- Clk  in  1  system clock; all state changes on rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Instr  in  32  instruction word from instruction memory; sampled only in FETCH.
- Zero  in  1  EXSTAGE ALU zero flag; valid in BRANCH state.
- Instr_LdEn  out  1  load enable of the datapath instruction register.
- PC_LdEn  out  1  PC update enable.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(SignExt(Imm)<<2).
- RF_WrEn  out  1  register-file write enable.
- RF_WrData_sel  out  1  0 = ALU_out, 1 = MEM_out.
- RF_B_sel  out  1  0 = read rt (Instr[15:11]), 1 = read rd (Instr[20:16]).
- ALU_Bin_sel  out  1  0 = RF_B, 1 = Immed.
- ALU_func  out  4  ALU operation code.
- MEM_WrEn  out  1  data-memory write enable.
- ByteOp  out  1  1 = byte access (lb/sb), 0 = word.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- Instr_count  out  32  number of retired legal instructions.

## Operation
- Internal opcode/func register is loaded from Instr[31:26]/Instr[5:0] in FETCH. Decode uses only this register.
- States and flows:
  - FETCH → DECODE for every instruction.
  - R-type (100000): DECODE → EXEC_R → WB_ALU.
  - ALU-immediate (li 111000, lui 111001, addi 110000, andi 110010, ori 110011): DECODE → EXEC_I → WB_ALU.
  - b 111111, beq 000000, bne 000001: DECODE → BRANCH.
  - Loads (lb 000011, lw 001111): DECODE → MEM_ADDR → MEM_RD → WB_MEM.
  - Stores (sb 000111, sw 011111): DECODE → MEM_ADDR → MEM_WR.
  - Every terminal state (WB_ALU, WB_MEM, BRANCH, MEM_WR) → FETCH.
  - Any other opcode: DECODE → FETCH.
- Outputs are combinational from state plus the latched opcode/func. Any output not listed below is 0.
- FETCH: Instr_LdEn=1.
- DECODE: RF_B_sel=1 for all non-R-type.
- EXEC_R, WB_ALU with R-type: ALU_func=func[3:0], ALU_Bin_sel=0, RF_B_sel=0.
- EXEC_I, WB_ALU with I-type: ALU_Bin_sel=1. ALU_func=0010 for andi, 0011 for ori, 0000 otherwise.
- WB_ALU: RF_WrEn=1, RF_WrData_sel=0.
- MEM_ADDR, MEM_RD, MEM_WR, WB_MEM: ALU_Bin_sel=1, ALU_func=0000, RF_B_sel=1, ByteOp=1 for lb/sb.
- MEM_WR: MEM_WrEn=1.
- WB_MEM: RF_WrEn=1, RF_WrData_sel=1.
- BRANCH: ALU_Bin_sel=0, RF_B_sel=1, ALU_func=0001.
  - PC_sel=1 for b; for beq when Zero=1; for bne when Zero=0.
  - Otherwise PC_sel=0.
- Retire: PC_LdEn=1 in every terminal state, and Instr_count increments by 1 in the same cycle.
- Illegal: in DECODE with an undefined opcode, Illegal=1 and PC_LdEn=1 with PC_sel=0. Instr_count is not incremented.
- Instr_count wraps from 0xFFFFFFFF to 0.

## Timing
- Reset, sampled on a rising edge with Rst_n=0:
  - state=FETCH, opcode register=0, Instr_count=0.
  - While Rst_n=0, every enable output, Illegal and PC_sel are forced to 0.
  - ALU_func reads 0000.
- Reset mid-instruction aborts it: no RF, PC or memory write occurs in the cycle Rst_n=0.
- The first FETCH (Instr_LdEn=1) occurs in the first cycle after Rst_n returns to 1.
- Instruction latency in cycles, FETCH to terminal state inclusive:
  - R-type and ALU-immediate: 4.
  - Branch: 3.
  - Load: 5.
  - Store: 4.
  - Illegal: 2.
- RF_WrEn, MEM_WrEn and PC_LdEn are single-cycle pulses. At most one of RF_WrEn or MEM_WrEn is high in any cycle.
- The latched opcode/func is stable from DECODE until the next FETCH edge. Changes on Instr outside FETCH have no effect.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with Instr=0x80231030 → all enables 0 and Instr_count=0. First cycle after release: Instr_LdEn=1.
- add r3,r1,r2 (0x80231030) → 4 cycles.
  - WB_ALU: RF_WrEn=1, RF_WrData_sel=0, ALU_func=0000, PC_LdEn=1, PC_sel=0.
  - Instr_count 0→1.
- lw r5,8(r1) (0x3C250008) → 5 cycles.
  - MEM_ADDR: ALU_Bin_sel=1, RF_B_sel=1.
  - WB_MEM: RF_WrEn=1, RF_WrData_sel=1, ByteOp=0.
- sw r5,4(r0) (0x7C050004) → MEM_WR has MEM_WrEn=1 and RF_WrEn=0. Then the same flow with sb (0x1C050004) → ByteOp=1.
- beq r1,r2,4 (0x00220004) → BRANCH: ALU_func=0001, PC_sel equals Zero for Zero=1 and Zero=0. bne (0x04220004) → PC_sel inverted. b (0xFC000004) → PC_sel=1.
- Illegal and wrap:
  - Instr=0xA8000000 → Illegal=1 in DECODE, PC_LdEn=1, count unchanged, next state FETCH.
  - Preload Instr_count to 0xFFFFFFFF (force), retire one instruction → 0x00000000.
  - Assert Rst_n=0 in MEM_WR → no MEM_WrEn pulse.
